// File: rtl/left_shift_pipe_if.sv
// Valid/ready bus for left_shift_pipe: producer side (i_*) and consumer side (o_*).
// The DUT uses the slave modport; the producer/consumer pair uses master.
interface left_shift_pipe_if #(
    parameter int unsigned width = 8
);
    localparam int unsigned S = $clog2(width);

    logic             i_valid;
    logic             i_ready;
    logic [width-1:0] i_bits;
    logic [S-1:0]     i_shift;
    logic             o_valid;
    logic             o_ready;
    logic [width-1:0] o_bits;

    modport master (
        output i_valid, i_bits, i_shift, o_ready,
        input  i_ready, o_valid, o_bits
    );

    modport slave (
        input  i_valid, i_bits, i_shift, o_ready,
        output i_ready, o_valid, o_bits
    );
endinterface

// File: rtl/left_shift_pipe.sv
// Pipelined left shifter: stage k shifts by 2^k when shift bit k is set.
// Elastic valid/ready pipeline with S = clog2(width) stages and per-stage stall.
module left_shift_pipe #(
    parameter int unsigned width = 8
) (
    input logic             clk,
    input logic             rst,
    left_shift_pipe_if.slave bus
);
    localparam int unsigned S = $clog2(width);

    logic             run_q;
    logic [S-1:0]     v_q;
    logic [S-1:0]     adv;
    logic [S-1:0]     src_v;
    logic [width-1:0] d_q   [S];
    logic [width-1:0] src_d [S];
    logic [S-1:0]     s_q   [S];
    logic [S-1:0]     src_s [S];

    always_comb begin
        src_v[0] = bus.i_valid & run_q;
        src_d[0] = bus.i_bits;
        src_s[0] = bus.i_shift;
        for (int k = 1; k < int'(S); k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic chain;
        chain    = ~v_q[S-1] | bus.o_ready;
        adv[S-1] = chain;
        for (int k = int'(S) - 2; k >= 0; k--) begin
            chain  = ~v_q[k] | chain;
            adv[k] = chain;
        end
    end

    // Shift amounts travel right-justified: each stage consumes bit 0 and passes the rest on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            v_q   <= '0;
            for (int k = 0; k < int'(S); k++) begin
                d_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            for (int k = 0; k < int'(S); k++) begin
                if (adv[k]) begin
                    v_q[k] <= src_v[k];
                    d_q[k] <= src_s[k][0] ? (src_d[k] << (2 ** k)) : src_d[k];
                    s_q[k] <= src_s[k] >> 1;
                end
            end
        end
    end

    assign bus.i_ready = adv[0] & run_q;
    assign bus.o_valid = v_q[S-1];
    assign bus.o_bits  = d_q[S-1];
endmodule
